// File: rtl/bio_gpio_filter_pkg.sv
// Shared defaults and pin-vector type for the BIO GPIO input filter.
package bio_gpio_pkg;

    localparam int NPIN_DEF = 32;
    localparam int CW_DEF   = 4;

    typedef logic [NPIN_DEF-1:0] pin_vec_t;

endpackage

// File: rtl/bio_gpio_filter_if.sv
// Pin-side bundle between the BIO core and the GPIO input filter.
interface bio_gpio_filter_if
    import bio_gpio_pkg::*;
#(
    parameter int NPIN = NPIN_DEF,
    parameter int CW   = CW_DEF
) ();

    logic [NPIN-1:0] pad_in;
    logic [NPIN-1:0] filt_en;
    logic [CW-1:0]   filt_len;
    logic [NPIN-1:0] rise_mask;
    logic [NPIN-1:0] fall_mask;
    logic [NPIN-1:0] pend_clr;
    logic [NPIN-1:0] gpio_in;
    logic [NPIN-1:0] rise;
    logic [NPIN-1:0] fall;
    logic [NPIN-1:0] pend;
    logic            edge_irq;

    modport master (
        output pad_in, filt_en, filt_len, rise_mask, fall_mask, pend_clr,
        input  gpio_in, rise, fall, pend, edge_irq
    );

    modport slave (
        input  pad_in, filt_en, filt_len, rise_mask, fall_mask, pend_clr,
        output gpio_in, rise, fall, pend, edge_irq
    );

endinterface

// File: rtl/bio_gpio_filter_filt_bit.sv
// One pin: 2-flop synchronizer, deglitch counter, accepted level and edge pulses.
module bio_gpio_filt_bit #(
    parameter int CW = 4
) (
    input  logic          fclk,
    input  logic          resetn,
    input  logic          pad,
    input  logic          en,
    input  logic [CW-1:0] len,
    output logic          level,
    output logic          rise,
    output logic          fall
);

    logic          sync1_reg;
    logic          sync2_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          level_reg;
    logic          level_next;
    logic          rise_reg;
    logic          fall_reg;

    // The counter only advances while below len, so it can never wrap even
    // when len is lowered mid-count; the >= compare accepts on the next cycle.
    always_comb begin
        cnt_next   = '0;
        level_next = level_reg;
        if (!en) begin
            level_next = sync2_reg;
        end else if (sync2_reg != level_reg) begin
            if (cnt_reg >= len) begin
                level_next = sync2_reg;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync1_reg <= pad;
            sync2_reg <= sync1_reg;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            // Pulses come from next vs current level so they line up with the level change.
            rise_reg  <= level_next & ~level_reg;
            fall_reg  <= ~level_next & level_reg;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/bio_gpio_filter.sv
// GPIO input filter: per-pin deglitch instances plus sticky edge-pending bits and IRQ.
module bio_gpio_filter
    import bio_gpio_pkg::*;
#(
    parameter int NPIN = NPIN_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic               fclk,
    input  logic               resetn,
    bio_gpio_filter_if.slave   bus
);

    logic [NPIN-1:0] level_w;
    logic [NPIN-1:0] rise_w;
    logic [NPIN-1:0] fall_w;
    logic [NPIN-1:0] pend_reg;
    logic [NPIN-1:0] pend_next;
    logic            edge_irq_reg;

    generate
        for (genvar gi = 0; gi < NPIN; gi++) begin : g_pin
            bio_gpio_filt_bit #(.CW(CW)) u_bit (
                .fclk   (fclk),
                .resetn (resetn),
                .pad    (bus.pad_in[gi]),
                .en     (bus.filt_en[gi]),
                .len    (bus.filt_len),
                .level  (level_w[gi]),
                .rise   (rise_w[gi]),
                .fall   (fall_w[gi])
            );
        end
    endgenerate

    // A new edge beats a simultaneous write-1-to-clear so no event is lost.
    always_comb begin
        pend_next = ((rise_w & bus.rise_mask) | (fall_w & bus.fall_mask))
                  | (pend_reg & ~bus.pend_clr);
    end

    always_ff @(posedge fclk or negedge resetn) begin
        if (!resetn) begin
            pend_reg     <= '0;
            edge_irq_reg <= 1'b0;
        end else begin
            pend_reg     <= pend_next;
            edge_irq_reg <= |pend_reg;
        end
    end

    assign bus.gpio_in  = level_w;
    assign bus.rise     = rise_w;
    assign bus.fall     = fall_w;
    assign bus.pend     = pend_reg;
    assign bus.edge_irq = edge_irq_reg;

endmodule

// File: tb/tb_bio_gpio_filter.sv
// Directed self-checking bench for bio_gpio_filter (bypass, deglitch, pending, reset).
module tb_bio_gpio_filter;
    import bio_gpio_pkg::*;

    logic fclk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    bio_gpio_filter_if #(.NPIN(32), .CW(4)) bus ();

    bio_gpio_filter #(.NPIN(32), .CW(4)) dut (
        .fclk   (fclk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp_v);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        resetn        = 1'b0;
        bus.pad_in    = '0;
        bus.filt_en   = '0;
        bus.filt_len  = 4'd0;
        bus.rise_mask = '0;
        bus.fall_mask = '0;
        bus.pend_clr  = '0;
        tick();
        tick();
        chk("rst_gpio", bus.gpio_in, 32'h0);
        chk("rst_pend", bus.pend, 32'h0);
        chk("rst_irq", {31'b0, bus.edge_irq}, 32'h0);
        resetn = 1'b1;
        tick();

        // Bypass: 3-cycle latency on pin 0
        bus.pad_in[0] = 1'b1;
        tick();
        chk("byp_c1", bus.gpio_in, 32'h0);
        tick();
        chk("byp_c2", bus.gpio_in, 32'h0);
        tick();
        chk("byp_c3_gpio", bus.gpio_in, 32'h1);
        chk("byp_c3_rise", bus.rise, 32'h1);
        tick();
        chk("byp_c4_rise", bus.rise, 32'h0);

        // Glitch reject: 4-cycle pulse on pin 5 with filt_len=4
        bus.filt_en[5] = 1'b1;
        bus.filt_len   = 4'd4;
        bus.pad_in[5]  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.pad_in[5] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("glitch_gpio", bus.gpio_in, 32'h1);
            chk("glitch_edges", bus.rise | bus.fall, 32'h0);
        end

        // Glitch accept: sustained level seen at cycle 7
        bus.pad_in[5] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("acc_wait", bus.gpio_in, 32'h1);
        end
        tick();
        chk("acc_c7_gpio", bus.gpio_in, 32'h21);
        chk("acc_c7_rise", bus.rise, 32'h20);
        tick();
        chk("acc_c8_rise", bus.rise, 32'h0);

        // filt_len=0 with filter on behaves as bypass (falling edge)
        bus.filt_len  = 4'd0;
        bus.pad_in[5] = 1'b0;
        tick();
        tick();
        chk("len0_c2", bus.gpio_in, 32'h21);
        tick();
        chk("len0_c3_gpio", bus.gpio_in, 32'h1);
        chk("len0_c3_fall", bus.fall, 32'h20);
        tick();
        chk("len0_c4_fall", bus.fall, 32'h0);

        // Pending on pin 2
        bus.rise_mask[2] = 1'b1;
        bus.fall_mask[2] = 1'b1;
        bus.pad_in[2]    = 1'b1;
        tick();
        tick();
        tick();
        chk("pend_rise", bus.rise, 32'h4);
        chk("pend_pre", bus.pend, 32'h0);
        tick();
        chk("pend_set", bus.pend, 32'h4);
        chk("irq_pre", {31'b0, bus.edge_irq}, 32'h0);
        tick();
        chk("irq_set", {31'b0, bus.edge_irq}, 32'h1);
        bus.pend_clr[2] = 1'b1;
        tick();
        bus.pend_clr[2] = 1'b0;
        chk("pend_clr", bus.pend, 32'h0);
        chk("irq_hold", {31'b0, bus.edge_irq}, 32'h1);
        tick();
        chk("irq_clr", {31'b0, bus.edge_irq}, 32'h0);

        // Set and clear together: set wins
        bus.pad_in[2] = 1'b0;
        tick();
        tick();
        tick();
        chk("sc_fall", bus.fall, 32'h4);
        bus.pend_clr[2] = 1'b1;
        tick();
        bus.pend_clr[2] = 1'b0;
        chk("sc_set_wins", bus.pend, 32'h4);
        bus.pend_clr[2] = 1'b1;
        tick();
        bus.pend_clr[2] = 1'b0;
        chk("sc_clr_after", bus.pend, 32'h0);

        // Unmasked edge does not set pending
        bus.rise_mask[2] = 1'b0;
        bus.pad_in[2]    = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mask_off", bus.pend, 32'h0);

        // Reset mid-activity with all pads high, then release
        bus.filt_en = '0;
        bus.pad_in  = '1;
        tick();
        resetn = 1'b0;
        #1;
        chk("rst2_gpio", bus.gpio_in, 32'h0);
        chk("rst2_rise", bus.rise, 32'h0);
        chk("rst2_fall", bus.fall, 32'h0);
        chk("rst2_pend", bus.pend, 32'h0);
        chk("rst2_irq", {31'b0, bus.edge_irq}, 32'h0);
        tick();
        tick();
        chk("rst2_hold", bus.gpio_in | bus.rise, 32'h0);
        resetn = 1'b1;
        tick();
        chk("rel_c1", bus.rise, 32'h0);
        tick();
        chk("rel_c2", bus.rise, 32'h0);
        tick();
        chk("rel_c3_rise", bus.rise, 32'hffff_ffff);
        chk("rel_c3_gpio", bus.gpio_in, 32'hffff_ffff);
        tick();
        chk("rel_c4_rise", bus.rise, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
